// File: rtl/hash_mem_pkg.sv
// Shared types for the hash-engine memory arbiter.
//   ADDR_W / DATA_W : default memory port widths
//   mem_req_t       : one engine access (write enable, address, write data)
//   arb_state_t     : arbiter FSM states
package hash_mem_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder.
//   req  in  N      : request vector
//   last in  IDX_W  : index granted most recently
//   any  out 1      : at least one request set
//   idx  out IDX_W  : first set request searching upward from last+1, wrapping
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    int pos;

    // Walk from the farthest offset down to the nearest so the closest
    // requester after 'last' is the final (winning) assignment.
    always_comb begin
        any = |req;
        idx = last;
        pos = 0;
        for (int k = N; k >= 1; k--) begin
            pos = (int'(last) + k) % N;
            if (req[pos[IDX_W-1:0]]) begin
                idx = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/hash_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between hash engines.
//   clk, reset        : system clock, asynchronous active-high reset
//   req/req_we        : per-engine request and write enable
//   req_addr/req_wdata: per-engine address and write data (flattened)
//   gnt, rvalid       : one-hot grant and read-data-valid (registered)
//   rdata, busy       : broadcast read data, port-owned flag
//   mem_*             : memory port (clock, registered we/addr/wdata, read data)
//
// state | meaning
// IDLE  | no owner; pick next requester round-robin from last+1
// OWN   | owner holds the port; one access per cycle while its req is high
module hash_mem_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = hash_mem_pkg::ADDR_W,
    parameter int DATA_W    = hash_mem_pkg::DATA_W,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic                      mem_clk,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_write_data,
    input  logic [DATA_W-1:0]         mem_read_data
);

    import hash_mem_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(NUM_REQ - 1);

    arb_state_t         state, state_n;
    logic [IDX_W-1:0]   owner, owner_n;
    logic [IDX_W-1:0]   last, last_n;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic               mem_we_n;
    logic [ADDR_W-1:0]  mem_addr_n;
    logic [DATA_W-1:0]  mem_write_data_n;

    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;

    logic               own_req, own_gnt, own_we;
    logic [ADDR_W-1:0]  own_addr;
    logic [DATA_W-1:0]  own_wdata;
    logic               accept;

    // Read tag pipe: stage 1 lines up with mem_addr, stage 2 is rvalid itself.
    logic               tag_v;
    logic [IDX_W-1:0]   tag_idx;

    rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req  (req),
        .last (last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    always_comb begin
        own_req   = 1'b0;
        own_gnt   = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == IDX_W'(i)) begin
                own_req   = req[i];
                own_gnt   = gnt[i];
                own_we    = req_we[i];
                own_addr  = req_addr[i*ADDR_W +: ADDR_W];
                own_wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_n          = state;
        owner_n          = owner;
        last_n           = last;
        burst_cnt_n      = burst_cnt;
        gnt_n            = gnt;
        mem_we_n         = 1'b0;
        mem_addr_n       = mem_addr;
        mem_write_data_n = mem_write_data;
        accept           = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    owner_n         = pick_idx;
                    last_n          = pick_idx;
                    gnt_n           = '0;
                    gnt_n[pick_idx] = 1'b1;
                    burst_cnt_n     = '0;
                    state_n         = OWN;
                end
            end
            OWN: begin
                if (own_req && own_gnt) begin
                    accept           = 1'b1;
                    mem_we_n         = own_we;
                    mem_addr_n       = own_addr;
                    mem_write_data_n = own_wdata;
                    burst_cnt_n      = burst_cnt + CNT_W'(1);
                    // The access that fills the burst is still performed;
                    // only the grant is withdrawn.
                    if (burst_cnt == BURST_LAST) begin
                        gnt_n   = '0;
                        state_n = IDLE;
                    end
                end else begin
                    gnt_n   = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            owner          <= '0;
            last           <= LAST_INIT;
            burst_cnt      <= '0;
            gnt            <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            tag_v          <= 1'b0;
            tag_idx        <= '0;
            rvalid         <= '0;
        end else begin
            state          <= state_n;
            owner          <= owner_n;
            last           <= last_n;
            burst_cnt      <= burst_cnt_n;
            gnt            <= gnt_n;
            mem_we         <= mem_we_n;
            mem_addr       <= mem_addr_n;
            mem_write_data <= mem_write_data_n;
            tag_v          <= accept && !own_we;
            tag_idx        <= owner;
            rvalid         <= '0;
            if (tag_v) begin
                rvalid[tag_idx] <= 1'b1;
            end
        end
    end

    assign busy    = |gnt;
    assign rdata   = mem_read_data;
    assign mem_clk = clk;

endmodule

// File: tb/tb_hash_mem_arbiter.sv
// Self-checking bench for hash_mem_arbiter: directed scenarios with literal
// expectations plus a long randomized run, all compared every cycle against a
// transaction-level model (owner / burst count / queue of pending read returns).
module tb_hash_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata, mem_read_data, mem_write_data;
    logic            busy, mem_clk, mem_we;
    logic [AW-1:0]   mem_addr;

    always #5 clk = ~clk;

    hash_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .gnt            (gnt),
        .rvalid         (rvalid),
        .rdata          (rdata),
        .busy           (busy),
        .mem_clk        (mem_clk),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Synchronous memory: read data one cycle after the address is sampled.
    logic [DW-1:0] mem [0:65535];
    always @(posedge clk) begin
        mem_read_data <= mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_write_data;
    end

    int n_checks = 0;
    int n_err    = 0;
    int ncyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           rd_q[$];
    logic [DW-1:0] mm [0:65535];
    int            m_owner, m_cnt, m_last;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [N-1:0]  exp_gnt, exp_rv;
    logic [N-1:0]  acc_seen;
    logic [AW-1:0] a_addr;

    always @(negedge clk) begin
        ncyc++;
        if (reset) begin
            m_owner = -1; m_cnt = 0; m_last = N - 1;
            e_we = 1'b0; e_addr = '0; e_wd = '0;
            rd_q.delete();
            acc_seen = '0;
            chk("rst_gnt", gnt, 0);
            chk("rst_rvalid", rvalid, 0);
            chk("rst_mem_we", mem_we, 0);
        end else begin
            exp_gnt = '0;
            if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
            chk("gnt", gnt, exp_gnt);
            chk("busy", busy, (m_owner >= 0));
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_write_data", mem_write_data, e_wd);
            chk("mem_clk", mem_clk, clk);
            exp_rv = '0;
            if (rd_q.size() > 0 && rd_q[0].due == ncyc) begin
                exp_rv[rd_q[0].idx] = 1'b1;
                chk("rdata", rdata, rd_q[0].data);
                void'(rd_q.pop_front());
            end
            chk("rvalid", rvalid, exp_rv);

            acc_seen = req & gnt;
            e_we = 1'b0;
            if (m_owner >= 0 && req[m_owner]) begin
                a_addr = req_addr[m_owner*AW +: AW];
                e_addr = a_addr;
                e_wd   = req_wdata[m_owner*DW +: DW];
                e_we   = req_we[m_owner];
                if (req_we[m_owner]) mm[a_addr] = e_wd;
                else rd_q.push_back('{due: ncyc + 2, idx: m_owner, data: mm[a_addr]});
                m_cnt++;
                if (m_cnt == MB) m_owner = -1;
            end else if (m_owner >= 0) begin
                m_owner = -1;
            end else if (req != 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (m_owner < 0 && req[(m_last + k) % N]) begin
                        m_owner = (m_last + k) % N;
                        m_last  = m_owner;
                        m_cnt   = 0;
                    end
                end
            end
        end
    end

    // ---------------- engine drivers ----------------
    int            rem   [N];
    int            wmode [N];
    logic [AW-1:0] ea    [N];
    logic          ew    [N];
    logic [DW-1:0] ed    [N];

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req[i]                = (rem[i] > 0);
            req_we[i]             = ew[i];
            req_addr[i*AW +: AW]  = ea[i];
            req_wdata[i*DW +: DW] = ed[i];
        end
    endtask

    task automatic new_access(input int i);
        ew[i] = (wmode[i] == 0) ? 1'b0 : (wmode[i] == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        ed[i] = $urandom;
    endtask

    task automatic start(input int i, input int n, input int addr, input int mode);
        rem[i]   = n;
        ea[i]    = AW'(addr);
        wmode[i] = mode;
        new_access(i);
        apply();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_seen[i] && rem[i] > 0) begin
                rem[i]--;
                ea[i]++;
                new_access(i);
            end
        end
        apply();
    endtask

    function automatic bit all_done();
        for (int i = 0; i < N; i++) if (rem[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    int   order[$];
    int   cnts[$];
    int   exp_order[8] = '{2, 3, 0, 1, 2, 3, 0, 1};
    int   exp_cnts[8]  = '{16, 16, 16, 16, 4, 4, 4, 4};
    logic [N-1:0] pg;
    bit   done;

    initial begin
        reset = 1'b1;
        acc_seen = '0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; wmode[i] = 0; ea[i] = '0; ew[i] = 1'b0; ed[i] = '0;
        end
        apply();
        for (int a = 0; a < 65536; a++) begin
            mem[a] = 32'(a) + 32'h100;
            mm[a]  = 32'(a) + 32'h100;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_gnt", gnt, 0);
        chk("reset_busy", busy, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_write_data, 0);
        chk("mem_clk_high", mem_clk, 1);
        #2 reset = 1'b0;
        tick();

        // Single reader: engine 0 reads 0..3.
        start(0, 4, 0, 0);
        for (int off = 0; off < 8; off++) begin
            @(negedge clk);
            chk("d1_gnt", gnt, (off >= 1 && off <= 5) ? 4'b0001 : 4'b0000);
            chk("d1_rvalid", rvalid, (off >= 3 && off <= 6) ? 4'b0001 : 4'b0000);
            if (off >= 3 && off <= 6) chk("d1_rdata", rdata, 32'h100 + 32'(off - 3));
            tick();
        end

        // Single write from engine 3.
        start(3, 1, 16'h0040, 1);
        ed[3] = 32'hDEADBEEF;
        apply();
        for (int off = 0; off < 6; off++) begin
            @(negedge clk);
            chk("d2_gnt", gnt, (off == 1 || off == 2) ? 4'b1000 : 4'b0000);
            chk("d2_mem_we", mem_we, (off == 2));
            if (off == 2) begin
                chk("d2_mem_addr", mem_addr, 32'h0040);
                chk("d2_mem_wdata", mem_write_data, 32'hDEADBEEF);
            end
            chk("d2_rvalid", rvalid, 0);
            tick();
        end

        // Forced release of engine 1 with reads in flight; engine 2 waiting.
        start(1, 20, 16'h0100, 0);
        start(2, 2, 16'h0200, 0);
        for (int off = 0; off < 31; off++) begin
            @(negedge clk);
            if (off == 16) chk("d3_gnt16", gnt, 4'b0010);
            if (off == 17) begin
                chk("d3_gnt17", gnt, 4'b0000);
                chk("d3_rv17", rvalid, 4'b0010);
                chk("d3_rd17", rdata, 32'h20E);
            end
            if (off == 18) begin
                chk("d3_gnt18", gnt, 4'b0100);
                chk("d3_rv18", rvalid, 4'b0010);
                chk("d3_rd18", rdata, 32'h20F);
            end
            if (off == 19) chk("d3_rv19", rvalid, 4'b0000);
            if (off == 20) begin
                chk("d3_rv20", rvalid, 4'b0100);
                chk("d3_rd20", rdata, 32'h300);
            end
            if (off == 22) chk("d3_gnt22", gnt, 4'b0010);
            tick();
        end

        // Reset mid-burst with reads in flight.
        start(0, 10, 16'h0300, 0);
        for (int off = 0; off < 4; off++) begin
            @(negedge clk);
            tick();
        end
        #1 reset = 1'b1;
        #1;
        chk("amid_gnt", gnt, 0);
        chk("amid_rvalid", rvalid, 0);
        chk("amid_busy", busy, 0);
        chk("amid_mem_we", mem_we, 0);
        chk("amid_mem_addr", mem_addr, 0);
        chk("amid_mem_wdata", mem_write_data, 0);
        for (int i = 0; i < N; i++) rem[i] = 0;
        apply();
        @(negedge clk);
        tick();
        #2 reset = 1'b0;
        for (int off = 0; off < 6; off++) begin
            @(negedge clk);
            chk("post_rst_rvalid", rvalid, 0);
            tick();
        end
        start(0, 2, 16'h0500, 0);
        start(1, 2, 16'h0600, 0);
        for (int off = 0; off < 12; off++) begin
            @(negedge clk);
            if (off == 1) chk("post_rst_first_gnt", gnt, 4'b0001);
            if (off == 5) chk("post_rst_second_gnt", gnt, 4'b0010);
            tick();
        end

        // Contention: all engines, 20 accesses each.
        for (int i = 0; i < N; i++) start(i, 20, 16'h0400 + i * 16'h40, 2);
        pg = '0;
        done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (gnt != 0 && gnt != pg) begin
                order.push_back(oh2i(gnt));
                cnts.push_back(0);
            end
            if ((gnt & req) != 0 && cnts.size() > 0) cnts[cnts.size() - 1]++;
            pg = gnt;
            done = all_done() && (gnt == 0);
            tick();
        end
        chk("cont_done", done, 1);
        chk("cont_ngrants", order.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < order.size()) begin
                chk("cont_order", order[k], exp_order[k]);
                chk("cont_accepts", cnts[k], exp_cnts[k]);
            end
        end

        // Randomized traffic.
        for (int t = 0; t < 3000; t++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (rem[i] == 0 && $urandom_range(0, 7) == 0)
                    start(i, $urandom_range(1, 24), $urandom_range(0, 1023), $urandom_range(0, 2));
            end
        end
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            done = all_done() && (gnt == 0) && (rd_q.size() == 0);
            tick();
        end
        chk("drain_done", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
